// File: rtl/fir_pkg.sv
// Shared constants and FSM state encoding for the FIR tap scheduler.
package fir_pkg;

    localparam int unsigned NTAPS  = 16;
    localparam int unsigned TAP_AW = 4;
    localparam int unsigned DW     = 16;

    typedef logic [1:0] fsm_state_t;

    localparam fsm_state_t StIdle  = 2'd0;
    localparam fsm_state_t StWrite = 2'd1;
    localparam fsm_state_t StRun   = 2'd2;

endpackage

// File: rtl/dec_4to16.sv
// 4-to-16 decoder with active-low one-hot output.
module dec_4to16
    import fir_pkg::*;
(
    input  logic [TAP_AW-1:0] addr,
    output logic [15:0]       dec_n
);

    always_comb begin
        dec_n       = '1;
        dec_n[addr] = 1'b0;
    end

endmodule

// File: rtl/fir_tap_sched.sv
// Tap scheduler for a time-multiplexed FIR MAC: sequences 16 taps per sample and
// arbitrates coefficient-bank writes, which lose to samples when both are requested.
module fir_tap_sched
    import fir_pkg::*;
#(
    parameter int unsigned NTAPS = fir_pkg::NTAPS,
    parameter int unsigned DW    = fir_pkg::DW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [TAP_AW-1:0] cfg_addr,
    input  logic [DW-1:0]     cfg_data,
    input  logic              smp_valid,
    output logic              smp_ready,
    output logic [15:0]       coef_we_n,
    output logic [DW-1:0]     coef_wdata,
    output logic [TAP_AW-1:0] tap_idx,
    output logic              tap_valid,
    output logic              tap_first,
    output logic              tap_last,
    output logic              busy
);

    localparam logic [TAP_AW-1:0] LastTap = TAP_AW'(NTAPS - 1);

    fsm_state_t        state_q, state_d;
    logic [TAP_AW-1:0] wr_addr_q, wr_addr_d;
    logic [DW-1:0]     wr_data_q, wr_data_d;
    logic [TAP_AW-1:0] tap_q, tap_d;
    logic [15:0]       dec_n, we_n_d, we_n_q;
    logic              smp_hs, cfg_hs;

    // Readies are forced low while reset is held, even though the state already reads IDLE.
    assign smp_ready = rst_n & (state_q == StIdle);
    assign cfg_ready = rst_n & (state_q == StIdle) & ~smp_valid;
    assign smp_hs    = smp_valid & smp_ready;
    assign cfg_hs    = cfg_valid & cfg_ready;

    always_comb begin
        state_d   = state_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        tap_d     = tap_q;
        case (state_q)
            StIdle: begin
                if (smp_hs) begin
                    state_d = StRun;
                    tap_d   = '0;
                end else if (cfg_hs) begin
                    state_d   = StWrite;
                    wr_addr_d = cfg_addr;
                    wr_data_d = cfg_data;
                end
            end
            StWrite: state_d = StIdle;
            StRun: begin
                if (tap_q == LastTap) begin
                    state_d = StIdle;
                    tap_d   = '0;
                end else begin
                    tap_d = tap_q + TAP_AW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                tap_d   = '0;
            end
        endcase
    end

    // Decode the address being captured so the registered strobe lines up with the WRITE cycle.
    dec_4to16 u_dec (
        .addr  (wr_addr_d),
        .dec_n (dec_n)
    );

    assign we_n_d = (state_d == StWrite) ? dec_n : '1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            tap_q     <= '0;
            we_n_q    <= '1;
        end else begin
            state_q   <= state_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            tap_q     <= tap_d;
            we_n_q    <= we_n_d;
        end
    end

    assign coef_we_n  = we_n_q;
    assign coef_wdata = wr_data_q;
    assign tap_idx    = tap_q;
    assign tap_valid  = (state_q == StRun);
    assign tap_first  = tap_valid & (tap_q == '0);
    assign tap_last   = tap_valid & (tap_q == LastTap);
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_fir_tap_sched.sv
// Self-checking bench for fir_tap_sched: behavioural model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_fir_tap_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        cfg_valid = 1'b0;
    logic        smp_valid = 1'b0;
    logic [3:0]  cfg_addr = '0;
    logic [15:0] cfg_data = '0;
    logic        cfg_ready, smp_ready, tap_valid, tap_first, tap_last, busy;
    logic [15:0] coef_we_n, coef_wdata;
    logic [3:0]  tap_idx;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fir_tap_sched #(.NTAPS(16), .DW(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .smp_valid  (smp_valid),
        .smp_ready  (smp_ready),
        .coef_we_n  (coef_we_n),
        .coef_wdata (coef_wdata),
        .tap_idx    (tap_idx),
        .tap_valid  (tap_valid),
        .tap_first  (tap_first),
        .tap_last   (tap_last),
        .busy       (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
        end
    endtask

    // Model: m_tap is the tap on show (-1 when no run), m_wr marks the single write cycle.
    int          m_tap  = -1;
    bit          m_wr   = 1'b0;
    int          m_addr = 0;
    logic [15:0] m_data = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_tap  <= -1;
            m_wr   <= 1'b0;
            m_addr <= 0;
            m_data <= '0;
        end else if (m_tap >= 0) begin
            m_tap <= (m_tap == 15) ? -1 : m_tap + 1;
        end else if (m_wr) begin
            m_wr <= 1'b0;
        end else if (smp_valid) begin
            m_tap <= 0;
        end else if (cfg_valid) begin
            m_wr   <= 1'b1;
            m_addr <= int'(cfg_addr);
            m_data <= cfg_data;
        end
    end

    always @(negedge clk) begin
        logic        e_idle;
        logic [15:0] e_we;
        #2;
        if (!rst_n) begin
            check("rst_smp_ready", smp_ready, 0);
            check("rst_cfg_ready", cfg_ready, 0);
            check("rst_tap_valid", tap_valid, 0);
            check("rst_tap_first", tap_first, 0);
            check("rst_tap_last", tap_last, 0);
            check("rst_tap_idx", tap_idx, 0);
            check("rst_busy", busy, 0);
            check("rst_we_n", coef_we_n, 16'hFFFF);
            check("rst_wdata", coef_wdata, 0);
        end else begin
            e_idle = (m_tap < 0) && !m_wr;
            e_we   = 16'hFFFF;
            if (m_wr) e_we[m_addr[3:0]] = 1'b0;
            check("smp_ready", smp_ready, e_idle);
            check("cfg_ready", cfg_ready, e_idle && !smp_valid);
            check("tap_valid", tap_valid, m_tap >= 0);
            check("tap_idx", tap_idx, (m_tap >= 0) ? m_tap : 0);
            check("tap_first", tap_first, m_tap == 0);
            check("tap_last", tap_last, m_tap == 15);
            check("busy", busy, !e_idle);
            check("coef_we_n", coef_we_n, e_we);
            if (m_wr) check("coef_wdata", coef_wdata, m_data);
        end
    end

    initial begin
        int          firsts[3];
        int          nf;
        logic [15:0] pat;
        logic [15:0] d;

        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #3;
        check("lit_rst_busy", busy, 0);
        check("lit_rst_we_n", coef_we_n, 16'hFFFF);
        check("lit_rst_smp_ready", smp_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #3;
        check("lit_idle_smp_ready", smp_ready, 1);
        check("lit_idle_cfg_ready", cfg_ready, 1);

        // Single config write
        @(negedge clk);
        cfg_valid = 1'b1; cfg_addr = 4'd5; cfg_data = 16'h1234;
        @(negedge clk);
        cfg_valid = 1'b0;
        #3;
        check("lit_wr5_we_n", coef_we_n, 16'hFFDF);
        check("lit_wr5_wdata", coef_wdata, 16'h1234);
        @(negedge clk);
        #3;
        check("lit_wr5_after", coef_we_n, 16'hFFFF);
        check("lit_wr5_busy", busy, 0);

        // Single sample run
        @(negedge clk);
        smp_valid = 1'b1;
        @(negedge clk);
        smp_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            #3;
            check("lit_run_idx", tap_idx, i);
            check("lit_run_valid", tap_valid, 1);
            check("lit_run_first", tap_first, i == 0);
            check("lit_run_last", tap_last, i == 15);
            @(negedge clk);
        end
        #3;
        check("lit_run_done_busy", busy, 0);

        // Arbitration: sample wins, config waits out the run
        @(negedge clk);
        cfg_valid = 1'b1; smp_valid = 1'b1; cfg_addr = 4'd15; cfg_data = 16'hABCD;
        #3;
        check("lit_arb_cfg_ready", cfg_ready, 0);
        @(negedge clk);
        smp_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            #3;
            check("lit_arb_hold", cfg_ready, 0);
            @(negedge clk);
        end
        #3;
        check("lit_arb_ready", cfg_ready, 1);
        @(negedge clk);
        cfg_valid = 1'b0;
        #3;
        check("lit_arb_we_n", coef_we_n, 16'h7FFF);
        @(negedge clk);

        // Throughput: back-to-back samples
        @(negedge clk);
        smp_valid = 1'b1;
        nf = 0;
        firsts = '{0, 0, 0};
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            #3;
            if (tap_first) begin
                if (nf < 3) firsts[nf] = c;
                nf++;
            end
        end
        @(negedge clk);
        smp_valid = 1'b0;
        check("lit_tput_count", nf, 3);
        check("lit_tput_first0", firsts[0], 1);
        check("lit_tput_first1", firsts[1], 18);
        check("lit_tput_first2", firsts[2], 35);
        repeat (12) @(negedge clk);

        // Reset mid-run at tap 7
        smp_valid = 1'b1;
        @(negedge clk);
        smp_valid = 1'b0;
        repeat (7) @(negedge clk);
        #3;
        check("lit_mid_idx7", tap_idx, 7);
        #1 rst_n = 1'b0;
        #2;
        check("lit_mid_rst_busy", busy, 0);
        check("lit_mid_rst_valid", tap_valid, 0);
        check("lit_mid_rst_idx", tap_idx, 0);
        check("lit_mid_rst_we_n", coef_we_n, 16'hFFFF);
        @(negedge clk);
        rst_n = 1'b1;
        #3;
        check("lit_mid_post_busy", busy, 0);

        // Sweep all coefficient addresses
        for (int a = 0; a < 16; a++) begin
            d = 16'($urandom);
            @(negedge clk);
            cfg_valid = 1'b1; cfg_addr = 4'(a); cfg_data = d;
            @(negedge clk);
            cfg_valid = 1'b0;
            #3;
            pat = 16'hFFFF;
            pat[a] = 1'b0;
            check("lit_sweep_we_n", coef_we_n, pat);
            check("lit_sweep_wdata", coef_wdata, d);
            @(negedge clk);
            #3;
            check("lit_sweep_idle", coef_we_n, 16'hFFFF);
        end

        // Randomized traffic with occasional resets
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            smp_valid = ($urandom_range(0, 3) == 0);
            cfg_valid = ($urandom_range(0, 2) == 0);
            cfg_addr  = 4'($urandom);
            cfg_data  = 16'($urandom);
            rst_n     = ($urandom_range(0, 199) != 0);
        end
        @(negedge clk);
        rst_n = 1'b1; smp_valid = 1'b0; cfg_valid = 1'b0;
        repeat (20) @(negedge clk);
        #4;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
